phys_reg_free_list: RTL

- Circular free list of physical register tags; sits directly upstream of the rename logic.
- Supplies the next free destination physical register each cycle a renamed instruction needs one.
- Reclaims tags released at commit, i.e. the old mapping of the committed destination.
- Rewinds its head on a pipeline squash so tags allocated to squashed instructions are reclaimed.

---
 rtl/phys_reg_free_list.sv | 120 ++++++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags feeding rename: zero-latency head tag, commit-time reclaim, squash rewind.
// Optional feature FREELIST_BYPASS_EN: when empty, a same-cycle release is forwarded straight to a requesting allocation.
module phys_reg_free_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_req,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic                     rel_valid,
    input  logic [TAG_W-1:0]         rel_tag,
    input  logic                     recover,
    input  logic [$clog2(DEPTH):0]   recover_cnt,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if (TAG_W != $clog2(PHYS_REGS)) begin : g_bad_tag_w
            $error("TAG_W must equal clog2(PHYS_REGS)");
        end
    endgenerate

    logic [TAG_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             empty;
    logic             full;
    logic             bypass_avail;
    logic             bypass_fire;
    logic             alloc_grant;
    logic             rel_acc;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   rewind_sum;
    logic [CNT_W:0]   count_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
`ifdef FREELIST_BYPASS_EN
        bypass_avail = empty && rel_valid;
`else
        bypass_avail = 1'b0;
`endif
        alloc_ready = !empty || bypass_avail;
        alloc_tag   = bypass_avail ? rel_tag : entry[head];
        // A forwarded tag never touches storage, so it must not also count as a release.
        bypass_fire = bypass_avail && alloc_req && !recover;
        alloc_grant = alloc_req && !empty && !recover;
        rel_acc     = rel_valid && !full && !bypass_fire;
    end

    always_comb begin
        // head + DEPTH - recover_cnt lies in [0, 2*DEPTH), so one conditional subtract wraps it.
        rewind_sum = (CNT_W+1)'(head) + (CNT_W+1)'(DEPTH) - (CNT_W+1)'(recover_cnt);
        if (rewind_sum >= (CNT_W+1)'(DEPTH)) begin
            rewind_sum = rewind_sum - (CNT_W+1)'(DEPTH);
        end

        if (recover) begin
            head_next = PTR_W'(rewind_sum);
        end else if (alloc_grant) begin
            head_next = ptr_inc(head);
        end else begin
            head_next = head;
        end

        tail_next = rel_acc ? ptr_inc(tail) : tail;

        count_sum = (CNT_W+1)'(count)
                  + (CNT_W+1)'(rel_acc)
                  + (recover ? (CNT_W+1)'(recover_cnt) : '0)
                  - (CNT_W+1)'(alloc_grant);
        count_next = CNT_W'(count_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= CNT_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            if (rel_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= TAG_W'(ARCH_REGS + i);
            end
        end else if (rel_acc) begin
            entry[tail] <= rel_tag;
        end
    end

    assign free_count = count;

endmodule
